// File: rtl/plb_dbg_pkg.sv
// Shared types and constants for the PLB debug snapshot sequencer.
// Provides the FSM state enum, error codes and err_ctrl field layout.
package plb_dbg_pkg;

   typedef enum logic [2:0] {
      ST_SHRST   = 3'd0,
      ST_RUN     = 3'd1,
      ST_FREEZE  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DUMP    = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_TIMEOUT = 3'd1;
   localparam logic [2:0] ERR_STRAY   = 3'd2;
   localparam logic [2:0] ERR_EMPTY   = 3'd3;

   localparam int ERR_CHAIN_LSB = 7;
   localparam int ERR_CODE_LSB  = 4;
   localparam int ERR_CNT_LSB   = 0;

   function automatic logic [11:0] err_pack(
      input logic [4:0] chain,
      input logic [2:0] code,
      input logic [3:0] cnt
   );
      logic [11:0] r;
      r = '0;
      r[ERR_CHAIN_LSB +: 5] = chain;
      r[ERR_CODE_LSB +: 3]  = code;
      r[ERR_CNT_LSB +: 4]   = cnt;
      return r;
   endfunction

endpackage

// File: rtl/plb_dbg_chain_collector.sv
// DUMP datapath: accepts words of the selected chain, folds the checksum,
// tracks word/idle counts and flags timeout, stray-valid and empty-chain.
// Ports: clk, rst, active (in DUMP), sel (chain index), sh_out, vld, done,
//        sum (checksum), chain_end (chain finished), err_code (this cycle).
module plb_dbg_chain_collector
   import plb_dbg_pkg::*;
#(
   parameter int NUM_CHAINS = 32,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  active,
   input  logic [4:0]            sel,
   input  logic [31:0]           sh_out,
   input  logic [NUM_CHAINS-1:0] vld,
   input  logic [NUM_CHAINS-1:0] done,
   output logic [15:0]           sum,
   output logic                  chain_end,
   output logic [2:0]            err_code
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   logic [IDLE_W-1:0]     idle;
   logic [15:0]           words;
   logic [NUM_CHAINS-1:0] mask;
   logic                  hit_vld;
   logic                  hit_done;
   logic                  stray;
   logic                  timeout;
   logic                  empty;

   always_comb begin
      mask = '0;
      mask[sel] = 1'b1;
      hit_vld  = active & vld[sel];
      hit_done = active & done[sel];
      stray    = active & (|(vld & ~mask));
      timeout  = active & ~hit_vld & ~hit_done &
                 (idle == IDLE_W'(TIMEOUT - 1));
      // a word arriving with done counts before the empty test
      empty     = hit_done & ~hit_vld & (words == '0);
      chain_end = hit_done | timeout;
      // simultaneous errors report the highest code
      err_code = ERR_NONE;
      if (empty)
         err_code = ERR_EMPTY;
      else if (stray)
         err_code = ERR_STRAY;
      else if (timeout)
         err_code = ERR_TIMEOUT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum   <= '0;
         idle  <= '0;
         words <= '0;
      end else begin
         if (hit_vld)
            sum <= sum + (sh_out[31:16] ^ sh_out[15:0]);
         if (!active || chain_end) begin
            idle  <= '0;
            words <= '0;
         end else begin
            if (hit_vld || hit_done)
               idle <= '0;
            else
               idle <= idle + IDLE_W'(1);
            if (hit_vld && words != '1)
               words <= words + 16'd1;
         end
      end
   end

endmodule

// File: rtl/plb_dbg_state_reader.sv
// Snapshot sequencer: reset shadow chains, run target, freeze, capture,
// dump each chain and report checksum / errors / status.
// Ports: clk, rst; gclk, sh_rst, c_en, dump_en drive the target/chains;
//        err_en, err_ctrl, dbg2, dbg3 report; sh_out*, dbg3_out are inputs.
module plb_dbg_state_reader
   import plb_dbg_pkg::*;
#(
   parameter int NUM_CHAINS    = 32,
   parameter int RUN_CYCLES    = 1024,
   parameter int SH_RST_CYCLES = 4,
   parameter int TIMEOUT       = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  gclk,
   output logic                  err_en,
   output logic [11:0]           err_ctrl,
   output logic                  sh_rst,
   output logic                  c_en,
   output logic [NUM_CHAINS-1:0] dump_en,
   output logic [15:0]           dbg2,
   output logic [7:0]            dbg3,
   input  logic [31:0]           sh_out,
   input  logic [NUM_CHAINS-1:0] sh_out_vld,
   input  logic [NUM_CHAINS-1:0] sh_out_done,
   input  logic [7:0]            dbg3_out
);

   localparam logic [4:0] LAST = 5'(NUM_CHAINS - 1);

   state_t                state;
   logic [31:0]           cnt;
   logic [4:0]            chain;
   logic [4:0]            chain_nx;
   logic [NUM_CHAINS-1:0] sel_nx;
   logic                  active;
   logic                  chain_end;
   logic [2:0]            err_code;
   logic [3:0]            err_cnt;

   assign active   = (state == ST_DUMP);
   assign chain_nx = chain + 5'd1;
   assign err_cnt  = (err_ctrl[ERR_CNT_LSB +: 4] == 4'hF) ? 4'hF :
                     err_ctrl[ERR_CNT_LSB +: 4] + 4'd1;

   always_comb begin
      sel_nx = '0;
      sel_nx[chain_nx] = 1'b1;
   end

   plb_dbg_chain_collector #(
      .NUM_CHAINS(NUM_CHAINS),
      .TIMEOUT   (TIMEOUT)
   ) u_coll (
      .clk      (clk),
      .rst      (rst),
      .active   (active),
      .sel      (chain),
      .sh_out   (sh_out),
      .vld      (sh_out_vld),
      .done     (sh_out_done),
      .sum      (dbg2),
      .chain_end(chain_end),
      .err_code (err_code)
   );

   // outputs are registered from the state being entered, so the
   // counters count visible cycles of each strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_SHRST;
         cnt      <= '0;
         chain    <= '0;
         gclk     <= 1'b0;
         sh_rst   <= 1'b0;
         c_en     <= 1'b0;
         dump_en  <= '0;
         dbg3     <= '0;
         err_en   <= 1'b0;
         err_ctrl <= '0;
      end else begin
         gclk   <= 1'b0;
         sh_rst <= 1'b0;
         c_en   <= 1'b0;
         if (err_code != ERR_NONE) begin
            err_en   <= 1'b1;
            err_ctrl <= err_pack(chain, err_code, err_cnt);
         end
         unique case (state)
            ST_SHRST: begin
               if (cnt < 32'(SH_RST_CYCLES)) begin
                  sh_rst <= 1'b1;
                  cnt    <= cnt + 32'd1;
                  dbg3   <= {ST_SHRST, 5'd0};
               end else begin
                  state <= ST_RUN;
                  gclk  <= 1'b1;
                  cnt   <= 32'd1;
                  dbg3  <= {ST_RUN, 5'd0};
               end
            end
            ST_RUN: begin
               if (cnt < 32'(RUN_CYCLES)) begin
                  gclk <= 1'b1;
                  cnt  <= cnt + 32'd1;
               end else begin
                  state <= ST_FREEZE;
                  dbg3  <= {ST_FREEZE, 5'd0};
               end
            end
            ST_FREEZE: begin
               state <= ST_CAPTURE;
               c_en  <= 1'b1;
               dbg3  <= {ST_CAPTURE, 5'd0};
            end
            ST_CAPTURE: begin
               state   <= ST_DUMP;
               chain   <= '0;
               dump_en <= {{(NUM_CHAINS-1){1'b0}}, 1'b1};
               dbg3    <= {ST_DUMP, 5'd0};
            end
            ST_DUMP: begin
               if (chain_end) begin
                  if (chain == LAST) begin
                     state   <= ST_DONE;
                     dump_en <= '0;
                     dbg3    <= dbg3_out;
                  end else begin
                     chain   <= chain_nx;
                     dump_en <= sel_nx;
                     dbg3    <= {ST_DUMP, chain_nx};
                  end
               end
            end
            ST_DONE: begin
               dbg3 <= dbg3_out;
            end
            default: begin
               state <= ST_SHRST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_plb_dbg_state_reader.sv
// Self-checking bench for plb_dbg_state_reader.
// Random chain traffic is scored against an event-level reference model.
module tb_plb_dbg_state_reader;

   localparam int NC  = 32;
   localparam int RC  = 1024;
   localparam int SRC = 4;
   localparam int TO  = 4096;

   logic          clk = 1'b0;
   logic          rst;
   logic          gclk;
   logic          err_en;
   logic [11:0]   err_ctrl;
   logic          sh_rst;
   logic          c_en;
   logic [NC-1:0] dump_en;
   logic [15:0]   dbg2;
   logic [7:0]    dbg3;
   logic [31:0]   sh_out;
   logic [NC-1:0] sh_out_vld;
   logic [NC-1:0] sh_out_done;
   logic [7:0]    dbg3_out;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_sum;
   logic [3:0]  m_cnt;
   logic [2:0]  m_code;
   logic [4:0]  m_chain;
   bit          m_err;
   int          m_i;
   int          m_words;
   int          m_idle;
   bit          m_done;

   plb_dbg_state_reader dut (
      .clk        (clk),
      .rst        (rst),
      .gclk       (gclk),
      .err_en     (err_en),
      .err_ctrl   (err_ctrl),
      .sh_rst     (sh_rst),
      .c_en       (c_en),
      .dump_en    (dump_en),
      .dbg2       (dbg2),
      .dbg3       (dbg3),
      .sh_out     (sh_out),
      .sh_out_vld (sh_out_vld),
      .sh_out_done(sh_out_done),
      .dbg3_out   (dbg3_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] m_ctrl();
      return {m_chain, m_code, m_cnt};
   endfunction

   function automatic logic [NC-1:0] m_dump();
      logic [NC-1:0] r;
      r = '0;
      if (!m_done)
         r[m_i] = 1'b1;
      return r;
   endfunction

   function automatic int pick_stray();
      return (m_i + 1 + int'($urandom_range(0, NC - 2))) % NC;
   endfunction

   task automatic model_reset();
      m_sum = '0; m_cnt = '0; m_code = '0; m_chain = '0;
      m_err = 0; m_i = 0; m_words = 0; m_idle = 0; m_done = 0;
   endtask

   // one DUMP cycle: v/d for the selected chain, st = stray valid on sc
   task automatic cyc(input bit v, input bit d, input bit st,
                      input logic [31:0] data, input int sc);
      logic [2:0] code;
      bit fin;
      sh_out = data;
      sh_out_vld = '0;
      sh_out_done = '0;
      if (v) sh_out_vld[m_i] = 1'b1;
      if (d) sh_out_done[m_i] = 1'b1;
      if (st) sh_out_vld[sc] = 1'b1;
      step();
      sh_out_vld = '0;
      sh_out_done = '0;
      sh_out = $urandom;
      if (!m_done) begin
         code = 3'd0;
         fin = 0;
         if (st) code = 3'd2;
         if (v) begin
            m_sum = m_sum + (data[31:16] ^ data[15:0]);
            m_words++;
         end
         if (v || d) m_idle = 0;
         else m_idle++;
         if (d) begin
            fin = 1;
            if (m_words == 0) code = 3'd3;
         end else if (m_idle == TO) begin
            fin = 1;
            if (code < 3'd1) code = 3'd1;
         end
         if (code != 3'd0) begin
            m_err = 1;
            m_chain = m_i[4:0];
            m_code = code;
            if (m_cnt != 4'hF) m_cnt++;
         end
         if (fin) begin
            m_i++;
            m_words = 0;
            m_idle = 0;
            if (m_i == NC) m_done = 1;
         end
      end
   endtask

   task automatic gap_cycle(input bit clean);
      if (!clean && $urandom_range(0, 3) == 0)
         cyc(0, 0, 1, $urandom, pick_stray());
      else
         cyc(0, 0, 0, $urandom, 0);
   endtask

   task automatic run_chain(input int nw, input bit clean);
      bit same;
      int gap;
      same = bit'($urandom_range(0, 1));
      for (int w = 0; w < nw; w++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) gap_cycle(clean);
         if (w == nw - 1 && same) cyc(1, 1, 0, $urandom, 0);
         else cyc(1, 0, 0, $urandom, 0);
      end
      if (nw == 0 || !same) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) gap_cycle(clean);
         cyc(0, 1, 0, $urandom, 0);
      end
   endtask

   task automatic wait_dump(input string tag);
      int n;
      n = 0;
      while (dump_en !== 32'h1 && n < 3000) begin
         step();
         n++;
      end
      checks++;
      if (dump_en !== 32'h1) begin
         errors++;
         $display("FAIL %s_wait dump_en=%h want 00000001", tag, dump_en);
      end
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1;
      repeat (3) step();
      checks++;
      if ({gclk, err_en, err_ctrl, sh_rst, c_en, dump_en, dbg2, dbg3} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0",
                  {gclk, err_en, err_ctrl, sh_rst, c_en, dump_en, dbg2, dbg3});
      end
      model_reset();
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < SRC; k++) begin
         step();
         if (!(sh_rst === 1'b1 && gclk === 1'b0)) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL sh_rst_window bad=%0d want 0", bad);
      end
      bad = 0;
      for (int k = 0; k < RC; k++) begin
         step();
         if (!(gclk === 1'b1 && sh_rst === 1'b0 && c_en === 1'b0)) bad++;
         if (k == 0) begin
            checks++;
            if (dbg3 !== 8'h20) begin
               errors++;
               $display("FAIL dbg3_run got %h want 20", dbg3);
            end
         end
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL gclk_window bad=%0d want 0", bad);
      end
      step();
      checks++;
      if ({gclk, c_en, sh_rst, dump_en} !== '0 || dbg3 !== 8'h40) begin
         errors++;
         $display("FAIL freeze gclk=%b c_en=%b dump_en=%h dbg3=%h want 0 0 0 40",
                  gclk, c_en, dump_en, dbg3);
      end
      step();
      checks++;
      if (c_en !== 1'b1 || gclk !== 1'b0 || dbg3 !== 8'h60) begin
         errors++;
         $display("FAIL capture c_en=%b gclk=%b dbg3=%h want 1 0 60", c_en, gclk, dbg3);
      end
      step();
      checks++;
      if (dump_en !== 32'h1 || c_en !== 1'b0 || dbg3 !== 8'h80) begin
         errors++;
         $display("FAIL dump0 dump_en=%h c_en=%b dbg3=%h want 00000001 0 80",
                  dump_en, c_en, dbg3);
      end
   endtask

   task automatic test_directed_chains();
      cyc(1, 0, 0, 32'h0001_0000, 0);
      cyc(0, 0, 0, $urandom, 0);
      cyc(1, 0, 0, 32'h1234_1234, 0);
      cyc(0, 1, 0, $urandom, 0);
      checks++;
      if (dbg2 !== 16'h0001 || dump_en !== 32'h2) begin
         errors++;
         $display("FAIL chain0 dbg2=%h dump_en=%h want 0001 00000002", dbg2, dump_en);
      end
      cyc(0, 0, 0, $urandom, 0);
      cyc(1, 1, 0, $urandom, 0);
      checks++;
      if (dump_en !== 32'h4 || dbg2 !== m_sum || err_en !== 1'b0) begin
         errors++;
         $display("FAIL chain1_same dump_en=%h dbg2=%h err_en=%b want 00000004 %h 0",
                  dump_en, dbg2, err_en, m_sum);
      end
      for (int c = 2; c < 5; c++) begin
         run_chain($urandom_range(1, 3), 1);
         checks++;
         if (dump_en !== m_dump() || dbg2 !== m_sum || err_en !== 1'b0) begin
            errors++;
            $display("FAIL clean_chain%0d dump_en=%h dbg2=%h err_en=%b want %h %h 0",
                     c, dump_en, dbg2, err_en, m_dump(), m_sum);
         end
      end
      repeat (TO - 1) cyc(0, 0, 0, $urandom, 0);
      checks++;
      if (dump_en !== 32'h20 || err_en !== 1'b0) begin
         errors++;
         $display("FAIL pre_timeout dump_en=%h err_en=%b want 00000020 0", dump_en, err_en);
      end
      cyc(0, 0, 0, $urandom, 0);
      checks++;
      if (err_en !== 1'b1 || err_ctrl !== 12'h291 || dump_en !== 32'h40) begin
         errors++;
         $display("FAIL timeout err_en=%b err_ctrl=%h dump_en=%h want 1 291 00000040",
                  err_en, err_ctrl, dump_en);
      end
   endtask

   task automatic test_random_chains();
      for (int c = 6; c < NC; c++) begin
         run_chain($urandom_range(0, 3), 0);
         checks++;
         if (dump_en !== m_dump() || dbg2 !== m_sum ||
             err_ctrl !== m_ctrl() || err_en !== m_err) begin
            errors++;
            $display("FAIL rand_chain%0d dump_en=%h dbg2=%h err_ctrl=%h err_en=%b want %h %h %h %b",
                     c, dump_en, dbg2, err_ctrl, err_en, m_dump(), m_sum, m_ctrl(), m_err);
         end
         if (!m_done) begin
            checks++;
            if (dbg3 !== {3'd4, m_i[4:0]}) begin
               errors++;
               $display("FAIL dbg3_dump%0d got %h want %h", c, dbg3, {3'd4, m_i[4:0]});
            end
         end
      end
   endtask

   task automatic test_done();
      logic [11:0] ec;
      logic [15:0] s;
      checks++;
      if (dump_en !== '0 || gclk !== 1'b0 || c_en !== 1'b0 ||
          sh_rst !== 1'b0 || dbg3 !== 8'h00) begin
         errors++;
         $display("FAIL done_entry dump_en=%h gclk=%b c_en=%b sh_rst=%b dbg3=%h want 0 0 0 0 00",
                  dump_en, gclk, c_en, sh_rst, dbg3);
      end
      dbg3_out = 8'hA5;
      step();
      checks++;
      if (dbg3 !== 8'hA5) begin
         errors++;
         $display("FAIL done_dbg3 got %h want a5", dbg3);
      end
      ec = m_ctrl();
      s = m_sum;
      for (int k = 0; k < 6; k++) begin
         sh_out_vld = $urandom;
         sh_out_done = $urandom;
         sh_out = $urandom;
         step();
      end
      sh_out_vld = '0;
      sh_out_done = '0;
      checks++;
      if (err_ctrl !== ec || dbg2 !== s || dump_en !== '0) begin
         errors++;
         $display("FAIL done_ignore err_ctrl=%h dbg2=%h dump_en=%h want %h %h 0",
                  err_ctrl, dbg2, dump_en, ec, s);
      end
   endtask

   task automatic test_stray_empty();
      logic [15:0] s;
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      wait_dump("rerun");
      checks++;
      if (err_en !== 1'b0 || err_ctrl !== 12'h000) begin
         errors++;
         $display("FAIL rerun_err err_en=%b err_ctrl=%h want 0 000", err_en, err_ctrl);
      end
      for (int c = 0; c < 3; c++) run_chain($urandom_range(1, 3), 1);
      s = dbg2;
      cyc(0, 0, 1, $urandom, 7);
      checks++;
      if (err_ctrl !== {5'd3, 3'd2, 4'd1} || err_ctrl !== m_ctrl() ||
          dbg2 !== s || dump_en !== 32'h8) begin
         errors++;
         $display("FAIL stray err_ctrl=%h dbg2=%h dump_en=%h want 1a1 %h 00000008",
                  err_ctrl, dbg2, dump_en, s);
      end
      cyc(0, 1, 0, $urandom, 0);
      checks++;
      if (err_ctrl !== {5'd3, 3'd3, 4'd2} || dump_en !== 32'h10 || err_en !== 1'b1) begin
         errors++;
         $display("FAIL empty err_ctrl=%h dump_en=%h err_en=%b want 1b2 00000010 1",
                  err_ctrl, dump_en, err_en);
      end
   endtask

   task automatic test_abort();
      for (int c = 4; c < 10; c++) run_chain($urandom_range(1, 2), 1);
      checks++;
      if (dump_en !== 32'h400 || dbg2 !== m_sum) begin
         errors++;
         $display("FAIL pre_abort dump_en=%h dbg2=%h want 00000400 %h", dump_en, dbg2, m_sum);
      end
      cyc(1, 0, 0, $urandom, 0);
      rst = 1'b1;
      step();
      checks++;
      if ({gclk, err_en, err_ctrl, sh_rst, c_en, dump_en, dbg2, dbg3} !== '0) begin
         errors++;
         $display("FAIL abort_outputs got %h want 0",
                  {gclk, err_en, err_ctrl, sh_rst, c_en, dump_en, dbg2, dbg3});
      end
      rst = 1'b0;
      model_reset();
      step();
      checks++;
      if (sh_rst !== 1'b1 || err_en !== 1'b0 || gclk !== 1'b0 || dump_en !== '0) begin
         errors++;
         $display("FAIL restart sh_rst=%b err_en=%b gclk=%b dump_en=%h want 1 0 0 0",
                  sh_rst, err_en, gclk, dump_en);
      end
      wait_dump("restart");
   endtask

   initial begin
      rst = 1'b1;
      sh_out = '0;
      sh_out_vld = '0;
      sh_out_done = '0;
      dbg3_out = 8'h00;
      test_reset();
      test_directed_chains();
      test_random_chains();
      test_done();
      dbg3_out = 8'h00;
      test_stray_empty();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
